// File: rtl/eeg_pea_eng_owb_if.sv
// Handshake bundle between the PE result stream, the write-back stage and the ORAM write port.
// The slave view is the write-back stage; the master view is its surroundings (PE + ORAM).
interface eeg_pea_eng_owb_if #(
    parameter int DATA_OUT_DW = 8,
    parameter int OMUX_ADD_AW = 8,
    parameter int ORAM_ADD_AW = 10,
    parameter int ORAM_PAK_NW = 4,
    parameter int ORAM_DAT_DW = DATA_OUT_DW * ORAM_PAK_NW
);
    logic                   DIN_VLD;
    logic                   DIN_LST;
    logic [OMUX_ADD_AW-1:0] DIN_ADD;
    logic [DATA_OUT_DW-1:0] DIN_DAT;
    logic                   DIN_RDY;
    logic                   ORAM_WEN;
    logic [ORAM_ADD_AW-1:0] ORAM_ADD;
    logic [ORAM_DAT_DW-1:0] ORAM_DAT;
    logic [ORAM_PAK_NW-1:0] ORAM_BEN;
    logic                   ORAM_RDY;

    modport slave (
        input  DIN_VLD, DIN_LST, DIN_ADD, DIN_DAT,
        output DIN_RDY,
        output ORAM_WEN, ORAM_ADD, ORAM_DAT, ORAM_BEN,
        input  ORAM_RDY
    );

    modport master (
        output DIN_VLD, DIN_LST, DIN_ADD, DIN_DAT,
        input  DIN_RDY,
        input  ORAM_WEN, ORAM_ADD, ORAM_DAT, ORAM_BEN,
        output ORAM_RDY
    );
endinterface

// File: rtl/eeg_pea_eng_owb.sv
// Output write-back stage: packs PE result bytes into ORAM words with byte enables,
// keeps a one-entry write buffer that drives the ORAM port from flops, and pulses
// DONE after the last word of a pass has been accepted.
module eeg_pea_eng_owb #(
    parameter int DATA_OUT_DW = 8,
    parameter int OMUX_ADD_AW = 8,
    parameter int ORAM_ADD_AW = 10,
    parameter int ORAM_PAK_NW = 4,
    parameter int ORAM_DAT_DW = DATA_OUT_DW * ORAM_PAK_NW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   IS_IDLE,
    input  logic [ORAM_ADD_AW-1:0] CFG_ORAM_BAS,
    eeg_pea_eng_owb_if.slave       bus,
    output logic                   DONE
);
    localparam int LW = $clog2(ORAM_PAK_NW);
    localparam int WW = OMUX_ADD_AW - LW;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PACK = 2'd1, ST_DRAIN = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [ORAM_DAT_DW-1:0] pk_dat_q, pk_dat_d;
    logic [ORAM_PAK_NW-1:0] pk_ben_q, pk_ben_d;
    logic [WW-1:0]          pk_widx_q, pk_widx_d;
    logic                   pend_q, pend_d;
    logic                   wen_q, wen_d;
    logic [ORAM_ADD_AW-1:0] wadd_q, wadd_d;
    logic [ORAM_DAT_DW-1:0] wdat_q, wdat_d;
    logic [ORAM_PAK_NW-1:0] wben_q, wben_d;
    logic                   done_q, done_d;

    logic [LW-1:0]          lane_s;
    logic [WW-1:0]          widx_s;
    logic                   wb_free_s, din_rdy_s, din_ena_s, wr_ena_s, fin_s, same_widx_s;
    logic [ORAM_DAT_DW-1:0] fresh_dat_s, merge_dat_s, push_dat_s;
    logic [ORAM_PAK_NW-1:0] fresh_ben_s, merge_ben_s, push_ben_s;
    logic [WW-1:0]          push_widx_s;
    logic                   push_s;

    // Decode the incoming result and build the fresh and merged pack candidates.
    always_comb begin
        lane_s      = bus.DIN_ADD[LW-1:0];
        widx_s      = bus.DIN_ADD[OMUX_ADD_AW-1:LW];
        wb_free_s   = ~wen_q | bus.ORAM_RDY;
        din_rdy_s   = wb_free_s & ~pend_q & (state_q != ST_DRAIN);
        din_ena_s   = bus.DIN_VLD & din_rdy_s;
        wr_ena_s    = wen_q & bus.ORAM_RDY;
        fin_s       = (lane_s == LW'(ORAM_PAK_NW - 1)) | bus.DIN_LST;
        same_widx_s = (widx_s == pk_widx_q);
        fresh_dat_s = '0;
        fresh_ben_s = '0;
        merge_dat_s = pk_dat_q;
        for (int k = 0; k < ORAM_PAK_NW; k++) begin
            if (lane_s == LW'(k)) begin
                fresh_dat_s[k*DATA_OUT_DW +: DATA_OUT_DW] = bus.DIN_DAT;
                merge_dat_s[k*DATA_OUT_DW +: DATA_OUT_DW] = bus.DIN_DAT;
                fresh_ben_s[k]                            = 1'b1;
            end else begin
                fresh_ben_s[k] = 1'b0;
            end
        end
        merge_ben_s = pk_ben_q | fresh_ben_s;
    end

    // Next state, pack register update and decision to push a word into the write buffer.
    always_comb begin
        state_d     = state_q;
        pk_dat_d    = pk_dat_q;
        pk_ben_d    = pk_ben_q;
        pk_widx_d   = pk_widx_q;
        pend_d      = pend_q;
        done_d      = 1'b0;
        push_s      = 1'b0;
        push_dat_s  = pk_dat_q;
        push_ben_s  = pk_ben_q;
        push_widx_s = pk_widx_q;
        case (state_q)
            ST_IDLE: begin
                if (din_ena_s) begin
                    pk_dat_d    = fresh_dat_s;
                    pk_ben_d    = fresh_ben_s;
                    pk_widx_d   = widx_s;
                    push_dat_s  = fresh_dat_s;
                    push_ben_s  = fresh_ben_s;
                    push_widx_s = widx_s;
                    push_s      = fin_s;
                    if (fin_s) begin
                        state_d = bus.DIN_LST ? ST_DRAIN : ST_IDLE;
                    end else begin
                        state_d = ST_PACK;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PACK: begin
                if (pend_q) begin
                    // Second push of a word that both started and finished in one result.
                    if (wb_free_s) begin
                        push_s  = 1'b1;
                        pend_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PACK;
                    end
                end else if (din_ena_s && same_widx_s) begin
                    pk_dat_d    = merge_dat_s;
                    pk_ben_d    = merge_ben_s;
                    push_dat_s  = merge_dat_s;
                    push_ben_s  = merge_ben_s;
                    push_s      = fin_s;
                    if (fin_s) begin
                        state_d = bus.DIN_LST ? ST_DRAIN : ST_IDLE;
                    end else begin
                        state_d = ST_PACK;
                    end
                end else if (din_ena_s) begin
                    // Address jumped to another word: flush the old pack, start afresh.
                    push_s    = 1'b1;
                    pk_dat_d  = fresh_dat_s;
                    pk_ben_d  = fresh_ben_s;
                    pk_widx_d = widx_s;
                    pend_d    = fin_s;
                    state_d   = (fin_s && bus.DIN_LST) ? ST_DRAIN : ST_PACK;
                end else begin
                    state_d = ST_PACK;
                end
            end
            ST_DRAIN: begin
                if (pend_q) begin
                    push_s = wb_free_s;
                    pend_d = ~wb_free_s;
                end else if (wr_ena_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (!wen_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    // Write buffer: load on push, otherwise drop the request once ORAM takes it.
    always_comb begin
        wen_d  = wen_q;
        wadd_d = wadd_q;
        wdat_d = wdat_q;
        wben_d = wben_q;
        if (push_s) begin
            wen_d  = 1'b1;
            wadd_d = CFG_ORAM_BAS + ORAM_ADD_AW'(push_widx_s);
            wdat_d = push_dat_s;
            wben_d = push_ben_s;
        end else if (wr_ena_s) begin
            wen_d = 1'b0;
        end else begin
            wen_d = wen_q;
        end
    end

    // Drive the ports from the buffer flops and the ready decode.
    always_comb begin
        bus.DIN_RDY  = din_rdy_s;
        bus.ORAM_WEN = wen_q;
        bus.ORAM_ADD = wadd_q;
        bus.ORAM_DAT = wdat_q;
        bus.ORAM_BEN = wben_q;
        DONE         = done_q;
        IS_IDLE      = (state_q == ST_IDLE) & ~wen_q;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pack register, write buffer and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_dat_q  <= '0;
            pk_ben_q  <= '0;
            pk_widx_q <= '0;
            pend_q    <= 1'b0;
            wen_q     <= 1'b0;
            wadd_q    <= '0;
            wdat_q    <= '0;
            wben_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            pk_dat_q  <= pk_dat_d;
            pk_ben_q  <= pk_ben_d;
            pk_widx_q <= pk_widx_d;
            pend_q    <= pend_d;
            wen_q     <= wen_d;
            wadd_q    <= wadd_d;
            wdat_q    <= wdat_d;
            wben_q    <= wben_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_eeg_pea_eng_owb.sv
// Directed table-driven bench for the output write-back stage.
// Each record is one clock cycle: inputs driven after the rising edge, outputs checked
// on the falling edge against hand-computed values.
module tb_eeg_pea_eng_owb;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       IS_IDLE, DONE;
    logic [9:0] CFG_ORAM_BAS;

    eeg_pea_eng_owb_if bus ();

    eeg_pea_eng_owb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IS_IDLE      (IS_IDLE),
        .CFG_ORAM_BAS (CFG_ORAM_BAS),
        .bus          (bus.slave),
        .DONE         (DONE)
    );

    always #5 clk = ~clk;

    // e_ctl = {DIN_RDY, ORAM_WEN, DONE, IS_IDLE}
    typedef struct {
        logic        vld;
        logic        lst;
        logic [7:0]  add;
        logic [7:0]  dat;
        logic        ordy;
        logic [9:0]  bas;
        logic [3:0]  e_ctl;
        logic [9:0]  e_add;
        logic [3:0]  e_ben;
        logic [31:0] e_dat;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    int   vnum   = 0;

    function automatic void v(input logic vld, input logic lst, input logic [7:0] add,
                              input logic [7:0] dat, input logic ordy, input logic [9:0] bas,
                              input logic [3:0] ctl, input logic [9:0] ea = 10'd0,
                              input logic [3:0] eb = 4'd0, input logic [31:0] ed = 32'd0);
        vec_t r;
        r.vld = vld; r.lst = lst; r.add = add; r.dat = dat; r.ordy = ordy; r.bas = bas;
        r.e_ctl = ctl; r.e_add = ea; r.e_ben = eb; r.e_dat = ed;
        vq.push_back(r);
    endfunction

    // Contiguous 8-result pass, last flag on index 7, ORAM always ready.
    function automatic void gen_full(input logic [9:0] bas, input logic [7:0] d0);
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            d = d0 + 8'(i);
            v(1'b1, 1'b0, 8'(i), d, 1'b1, bas, (i == 0) ? 4'b1001 : 4'b1000);
        end
        v(1'b1, 1'b0, 8'd4, d0 + 8'd4, 1'b1, bas, 4'b1100, bas, 4'hF,
          {d0 + 8'd3, d0 + 8'd2, d0 + 8'd1, d0});
        for (int i = 5; i < 8; i++) begin
            d = d0 + 8'(i);
            v(1'b1, (i == 7), 8'(i), d, 1'b1, bas, 4'b1000);
        end
        v(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, bas, 4'b0100, bas + 10'd1, 4'hF,
          {d0 + 8'd7, d0 + 8'd6, d0 + 8'd5, d0 + 8'd4});
        v(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, bas, 4'b1011);
    endfunction

    task automatic run_vecs();
        for (int i = 0; i < vq.size(); i++) begin
            CFG_ORAM_BAS = vq[i].bas;
            bus.DIN_VLD  = vq[i].vld;
            bus.DIN_LST  = vq[i].lst;
            bus.DIN_ADD  = vq[i].add;
            bus.DIN_DAT  = vq[i].dat;
            bus.ORAM_RDY = vq[i].ordy;
            @(negedge clk);
            checks++;
            if ({bus.DIN_RDY, bus.ORAM_WEN, DONE, IS_IDLE} !== vq[i].e_ctl) begin
                errors++;
                $display("FAIL vec%0d ctl(rdy,wen,done,idle) got %b want %b", vnum,
                         {bus.DIN_RDY, bus.ORAM_WEN, DONE, IS_IDLE}, vq[i].e_ctl);
            end
            if (vq[i].e_ctl[2]) begin
                checks++;
                if ({bus.ORAM_ADD, bus.ORAM_BEN, bus.ORAM_DAT} !==
                    {vq[i].e_add, vq[i].e_ben, vq[i].e_dat}) begin
                    errors++;
                    $display("FAIL vec%0d word got add=%h ben=%b dat=%h want add=%h ben=%b dat=%h",
                             vnum, bus.ORAM_ADD, bus.ORAM_BEN, bus.ORAM_DAT,
                             vq[i].e_add, vq[i].e_ben, vq[i].e_dat);
                end
            end
            vnum++;
            @(posedge clk);
            #1;
        end
        vq.delete();
    endtask

    task automatic chk_reset(input string nm);
        checks++;
        if ({bus.DIN_RDY, bus.ORAM_WEN, DONE, IS_IDLE, bus.ORAM_ADD, bus.ORAM_BEN, bus.ORAM_DAT} !==
            {4'b1001, 10'd0, 4'd0, 32'd0}) begin
            errors++;
            $display("FAIL %s got rdy/wen/done/idle=%b add=%h ben=%b dat=%h want 1001 and zeros", nm,
                     {bus.DIN_RDY, bus.ORAM_WEN, DONE, IS_IDLE}, bus.ORAM_ADD, bus.ORAM_BEN,
                     bus.ORAM_DAT);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        CFG_ORAM_BAS = 10'h100;
        bus.DIN_VLD  = 1'b0;
        bus.DIN_LST  = 1'b0;
        bus.DIN_ADD  = 8'd0;
        bus.DIN_DAT  = 8'd0;
        bus.ORAM_RDY = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Contiguous 0..7
        gen_full(10'h100, 8'h10);

        // 0..5, last on 5: partial second word
        v(1'b1, 1'b0, 8'd0, 8'h20, 1'b1, 10'h100, 4'b1001);
        v(1'b1, 1'b0, 8'd1, 8'h21, 1'b1, 10'h100, 4'b1000);
        v(1'b1, 1'b0, 8'd2, 8'h22, 1'b1, 10'h100, 4'b1000);
        v(1'b1, 1'b0, 8'd3, 8'h23, 1'b1, 10'h100, 4'b1000);
        v(1'b1, 1'b0, 8'd4, 8'h24, 1'b1, 10'h100, 4'b1100, 10'h100, 4'hF, 32'h23222120);
        v(1'b1, 1'b1, 8'd5, 8'h25, 1'b1, 10'h100, 4'b1000);
        v(1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 10'h100, 4'b0100, 10'h101, 4'b0011, 32'h00002524);
        v(1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 10'h100, 4'b1011);

        // Stride 2: 0,2,4,6
        v(1'b1, 1'b0, 8'd0, 8'h30, 1'b1, 10'h100, 4'b1001);
        v(1'b1, 1'b0, 8'd2, 8'h32, 1'b1, 10'h100, 4'b1000);
        v(1'b1, 1'b0, 8'd4, 8'h34, 1'b1, 10'h100, 4'b1000);
        v(1'b1, 1'b1, 8'd6, 8'h36, 1'b1, 10'h100, 4'b1100, 10'h100, 4'b0101, 32'h00320030);
        v(1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 10'h100, 4'b0100, 10'h101, 4'b0101, 32'h00360034);
        v(1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 10'h100, 4'b1011);

        // Jump 0 -> 7 with last: old pack flushed, new word pending a second push
        v(1'b1, 1'b0, 8'd0, 8'h60, 1'b1, 10'h100, 4'b1001);
        v(1'b1, 1'b1, 8'd7, 8'h61, 1'b1, 10'h100, 4'b1000);
        v(1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 10'h100, 4'b0100, 10'h100, 4'b0001, 32'h00000060);
        v(1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 10'h100, 4'b0100, 10'h101, 4'b1000, 32'h61000000);
        v(1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 10'h100, 4'b1011);

        // ORAM stall for 5 cycles after the first word
        v(1'b1, 1'b0, 8'd0, 8'h40, 1'b1, 10'h100, 4'b1001);
        v(1'b1, 1'b0, 8'd1, 8'h41, 1'b1, 10'h100, 4'b1000);
        v(1'b1, 1'b0, 8'd2, 8'h42, 1'b1, 10'h100, 4'b1000);
        v(1'b1, 1'b0, 8'd3, 8'h43, 1'b1, 10'h100, 4'b1000);
        for (int i = 0; i < 5; i++) begin
            v(1'b1, 1'b0, 8'd4, 8'h44, 1'b0, 10'h100, 4'b0100, 10'h100, 4'hF, 32'h43424140);
        end
        v(1'b1, 1'b0, 8'd4, 8'h44, 1'b1, 10'h100, 4'b1100, 10'h100, 4'hF, 32'h43424140);
        v(1'b1, 1'b0, 8'd5, 8'h45, 1'b1, 10'h100, 4'b1000);
        v(1'b1, 1'b0, 8'd6, 8'h46, 1'b1, 10'h100, 4'b1000);
        v(1'b1, 1'b1, 8'd7, 8'h47, 1'b1, 10'h100, 4'b1000);
        v(1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 10'h100, 4'b0100, 10'h101, 4'hF, 32'h47464544);
        v(1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 10'h100, 4'b1011);

        // Base address wrap
        gen_full(10'h3FF, 8'h50);
        run_vecs();

        // Reset while a write is outstanding
        CFG_ORAM_BAS = 10'h100;
        bus.ORAM_RDY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.DIN_VLD = 1'b1;
            bus.DIN_LST = 1'b0;
            bus.DIN_ADD = 8'(i);
            bus.DIN_DAT = 8'h80 + 8'(i);
            @(posedge clk);
            #1;
        end
        bus.DIN_VLD  = 1'b0;
        bus.ORAM_RDY = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ORAM_WEN !== 1'b1) begin
            errors++;
            $display("FAIL midpass_wen got %b want 1", bus.ORAM_WEN);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("midpass_reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean pass after reset: 0..3, last on 3
        v(1'b1, 1'b0, 8'd0, 8'h70, 1'b1, 10'h100, 4'b1001);
        v(1'b1, 1'b0, 8'd1, 8'h71, 1'b1, 10'h100, 4'b1000);
        v(1'b1, 1'b0, 8'd2, 8'h72, 1'b1, 10'h100, 4'b1000);
        v(1'b1, 1'b1, 8'd3, 8'h73, 1'b1, 10'h100, 4'b1000);
        v(1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 10'h100, 4'b0100, 10'h100, 4'hF, 32'h73727170);
        v(1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 10'h100, 4'b1011);
        v(1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 10'h100, 4'b1001);
        run_vecs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
